// File: rtl/regfile_pkg.sv
// Shared types and widths for the register-file write arbiter.
package regfile_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wr_beat_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Request/grant bus plus the regfile write port; the bypass signals exist only
// when REGFILE_WB_FORWARD_EN is defined.
interface regfile_write_arbiter_if
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
);

  logic                             hold;
  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ-1:0]               req_ready;
  logic [NUM_REQ-1:0]               req_lock;
  logic [NUM_REQ*REG_ADDR_W-1:0]    req_addr;
  logic [NUM_REQ*REG_DATA_W-1:0]    req_data;
  logic [REG_ADDR_W-1:0]            WriteRegister;
  logic [REG_DATA_W-1:0]            WriteData;
  logic                             RegWrite;
  logic                             busy;
`ifdef REGFILE_WB_FORWARD_EN
  logic [REG_ADDR_W-1:0]            fwd_addr1;
  logic [REG_ADDR_W-1:0]            fwd_addr2;
  logic [REG_DATA_W-1:0]            fwd_in1;
  logic [REG_DATA_W-1:0]            fwd_in2;
  logic [REG_DATA_W-1:0]            fwd_out1;
  logic [REG_DATA_W-1:0]            fwd_out2;
`endif

  modport master (
    output hold, req_valid, req_lock, req_addr, req_data,
    input  req_ready, WriteRegister, WriteData, RegWrite, busy
`ifdef REGFILE_WB_FORWARD_EN
    , output fwd_addr1, fwd_addr2, fwd_in1, fwd_in2
    , input  fwd_out1, fwd_out2
`endif
  );

  modport slave (
    input  hold, req_valid, req_lock, req_addr, req_data,
    output req_ready, WriteRegister, WriteData, RegWrite, busy
`ifdef REGFILE_WB_FORWARD_EN
    , input  fwd_addr1, fwd_addr2, fwd_in1, fwd_in2
    , output fwd_out1, fwd_out2
`endif
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid index at or above ptr, wrapping.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          found
);

  logic [IW:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned off = 0; off < N; off++) begin
      cand = {1'b0, ptr} + (IW+1)'(off);
      if (32'(cand) >= N) cand = cand - (IW+1)'(N);
      if (!found && valid[cand[IW-1:0]]) begin
        found                 = 1'b1;
        idx                   = cand[IW-1:0];
        grant[cand[IW-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter with burst lock sharing the single regfile write port.
// Defining REGFILE_WB_FORWARD_EN adds a combinational bypass of the pending write.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_BURST = 4
) (
  input logic                    clk,
  input logic                    reset,
  regfile_write_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = 4;

  arb_state_e         state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   owner;
  logic [CNT_W-1:0]   beat_cnt;
  wr_beat_t           out_q;
  logic               wr_en_q;
  logic               busy_q;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;

  logic [NUM_REQ-1:0] grant_c;
  logic [IDX_W-1:0]   win_idx_c;
  logic [IDX_W-1:0]   next_ptr_c;
  logic               xfer_c;
  logic               drop_c;
  logic               win_lock_c;
  logic               last_beat_c;
  logic               enter_lock_c;
  logic               next_locked_c;
  logic               wr_en_next_c;
  wr_beat_t           win_beat_c;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IDX_W)
  ) u_pick (
    .valid (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Grant: free round-robin in ARB, owner only in LOCKED; nothing under hold or reset.
  always_comb begin
    grant_c   = '0;
    win_idx_c = '0;
    xfer_c    = 1'b0;
    drop_c    = 1'b0;
    if (!reset && !bus.hold) begin
      if (state == ARB) begin
        grant_c   = pick_grant;
        win_idx_c = pick_idx;
        xfer_c    = pick_found;
      end else if (bus.req_valid[owner]) begin
        grant_c[owner] = 1'b1;
        win_idx_c      = owner;
        xfer_c         = 1'b1;
      end else begin
        drop_c = 1'b1;
      end
    end
  end

  assign bus.req_ready = grant_c;

  always_comb begin
    win_beat_c.addr = bus.req_addr[REG_ADDR_W*32'(win_idx_c) +: REG_ADDR_W];
    win_beat_c.data = bus.req_data[REG_DATA_W*32'(win_idx_c) +: REG_DATA_W];
    win_lock_c      = bus.req_lock[win_idx_c];
    last_beat_c     = !win_lock_c || ((beat_cnt + CNT_W'(1)) == CNT_W'(MAX_BURST));
    enter_lock_c    = xfer_c && (state == ARB) && win_lock_c && (MAX_BURST > 1);
    next_locked_c   = enter_lock_c ||
                      ((state == LOCKED) && !drop_c && !(xfer_c && last_beat_c));
    wr_en_next_c    = xfer_c && (win_beat_c.addr != REG_ZERO);
    next_ptr_c      = (win_idx_c == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx_c + IDX_W'(1);
  end

  // FSM, pointer, burst counter and output stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ARB;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
      out_q    <= '0;
      wr_en_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      wr_en_q <= wr_en_next_c;
      busy_q  <= next_locked_c || wr_en_next_c;
      if (xfer_c) begin
        out_q  <= win_beat_c;
        rr_ptr <= next_ptr_c;
      end
      case (state)
        ARB: begin
          if (enter_lock_c) begin
            state    <= LOCKED;
            owner    <= win_idx_c;
            beat_cnt <= CNT_W'(1);
          end
        end
        LOCKED: begin
          if (!next_locked_c) begin
            state    <= ARB;
            beat_cnt <= '0;
          end else if (xfer_c) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  assign bus.WriteRegister = out_q.addr;
  assign bus.WriteData     = out_q.data;
  assign bus.RegWrite      = wr_en_q;
  assign bus.busy          = busy_q;

`ifdef REGFILE_WB_FORWARD_EN
  // Bypass the write sitting in the output stage to same-cycle readers.
  assign bus.fwd_out1 = (wr_en_q && (out_q.addr == bus.fwd_addr1) && (bus.fwd_addr1 != REG_ZERO))
                        ? out_q.data : bus.fwd_in1;
  assign bus.fwd_out2 = (wr_en_q && (out_q.addr == bus.fwd_addr2) && (bus.fwd_addr2 != REG_ZERO))
                        ? out_q.data : bus.fwd_in2;
`endif

endmodule
